spi_slave_miso_tx: RTL and testbench

//  Slave-side SPI transmitter (mode 0, CPOL=0/CPHA=0). Serialises parallel words onto MISO

---
 rtl/spi_slave_miso_tx.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave_miso_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_miso_tx.sv
// Slave-side SPI mode-0 transmitter: oversamples SCLK/CS_N, serialises words from a
// one-word holding buffer onto a registered MISO with tristate enable.
module spi_slave_miso_tx #(
  parameter int WIDTH       = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  output logic             miso,
  output logic             miso_oe,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic             abort
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic [WIDTH-1:0]       r_buf;
  logic                   r_buf_full;
  logic [WIDTH-1:0]       r_shreg;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_miso;
  logic                   r_done;
  logic                   r_underrun;
  logic                   r_abort;

  logic                   w_sclk;
  logic                   w_cs_n;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_load_acc;
  logic                   w_start;
  logic                   w_take;
  logic                   w_underrun;
  logic                   w_word_end;
  logic                   w_shift;
  logic                   w_count;
  logic                   w_exit;
  logic                   w_abort;
  logic                   w_shreg_out;
  logic [WIDTH-1:0]       w_shreg_shifted;

  // Synchronisers idle at the bus-quiet levels so a reset release never looks like an edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_in};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs_n;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_cs_rise   = w_cs_n & ~r_cs_prev;
  assign w_cs_fall   = ~w_cs_n & r_cs_prev;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shreg_out     = r_shreg[WIDTH-1];
      assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_shreg_out     = r_shreg[0];
      assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cs_fall) w_state_next = S_SHIFT;
      S_SHIFT: if (w_cs_rise) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // cs_n rising wins over any sclk edge seen in the same cycle.
  always_comb begin
    w_exit     = 1'b0;
    w_abort    = 1'b0;
    w_word_end = 1'b0;
    w_shift    = 1'b0;
    w_count    = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = w_cs_fall;
      end
      S_SHIFT: begin
        if (w_cs_rise) begin
          w_exit  = 1'b1;
          w_abort = (r_bit_cnt != '0);
        end else if (w_sclk_fall) begin
          if (r_bit_cnt == CNT_MAX) begin
            w_word_end = 1'b1;
            w_start    = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end else if (w_sclk_rise) begin
          w_count = (r_bit_cnt < CNT_MAX);
        end
      end
      default: begin
        w_exit = 1'b0;
      end
    endcase
  end

  assign w_take     = w_start & r_buf_full;
  assign w_underrun = w_start & ~r_buf_full;
  assign w_load_acc = load & ~r_buf_full;

  // A load and a transfer can never coincide: one needs the buffer empty, the other full.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_load_acc) begin
        r_buf      <= data_in;
        r_buf_full <= 1'b1;
      end else if (w_take) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_exit) begin
        r_shreg   <= '0;
        r_bit_cnt <= '0;
      end else if (w_start) begin
        r_shreg   <= r_buf_full ? r_buf : '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_shift) r_shreg <= w_shreg_shifted;
        if (w_count) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // MISO trails the shift register by one cycle and is forced low outside a word.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_miso     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_miso     <= (r_state == S_SHIFT && !w_exit) ? w_shreg_out : 1'b0;
      r_done     <= w_word_end;
      r_underrun <= w_underrun;
      r_abort    <= w_abort;
    end
  end

  assign ready    = ~r_buf_full;
  assign miso     = r_miso;
  assign miso_oe  = (r_state == S_SHIFT);
  assign busy     = (r_state == S_SHIFT);
  assign done     = r_done;
  assign underrun = r_underrun;
  assign abort    = r_abort;

endmodule

// File: tb/tb_spi_slave_miso_tx.sv
// Bench for spi_slave_miso_tx: an MSB-first and an LSB-first instance share one SPI master
// model; expected MISO bits are queued at load time and checked at each SCLK rise.
module tb_spi_slave_miso_tx;

  localparam int HALF = 8;

  typedef struct {
    logic [7:0] word;
    bit         preload;
    int         exp_und_start;
  } vec_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       load = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;

  logic [1:0] ready_v, miso_v, oe_v, busy_v, done_v, und_v, abort_v;

  int n_checks = 0;
  int n_errors = 0;
  int done_c[2];
  int und_c[2];
  int abort_c[2];

  logic q0[$];
  logic q1[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  spi_slave_miso_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_msb (
    .clk(clk), .clrn(clrn), .data_in(data_in), .load(load), .ready(ready_v[0]),
    .sclk_in(sclk), .cs_n_in(cs_n), .miso(miso_v[0]), .miso_oe(oe_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .underrun(und_v[0]), .abort(abort_v[0])
  );

  spi_slave_miso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_lsb (
    .clk(clk), .clrn(clrn), .data_in(data_in), .load(load), .ready(ready_v[1]),
    .sclk_in(sclk), .cs_n_in(cs_n), .miso(miso_v[1]), .miso_oe(oe_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .underrun(und_v[1]), .abort(abort_v[1])
  );

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done_v[k])  done_c[k]  <= done_c[k] + 1;
      if (und_v[k])   und_c[k]   <= und_c[k] + 1;
      if (abort_v[k]) abort_c[k] <= abort_c[k] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q0.push_back(w[i]);
    for (int i = 0; i < 8; i++) q1.push_back(w[i]);
  endtask

  task automatic do_load(input logic [7:0] w, input bit exp_ready);
    @(negedge clk);
    chk("ready_at_load", ready_v, {2{exp_ready}});
    data_in = w;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("ready_after_load", ready_v, 2'b00);
    if (exp_ready) push_word(w);
  endtask

  task automatic sclk_rise();
    logic e0, e1;
    @(negedge clk);
    if (q0.size() == 0 || q1.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got miso %b with no expected bit queued", miso_v);
    end else begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      chk("miso_msb_first", miso_v[0], e0);
      chk("miso_lsb_first", miso_v[1], e1);
    end
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic sclk_fall();
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic set_cs(input logic v);
    cs_n = v;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic transfer(input int nbits, input int exp_und_start, input bit mid_load,
                          input logic [7:0] mid_word);
    int d0[2], u0[2], a0[2];
    d0 = done_c;
    u0 = und_c;
    a0 = abort_c;
    set_cs(1'b0);
    for (int k = 0; k < 2; k++) chk("underrun_at_select", und_c[k] - u0[k], exp_und_start);
    chk("miso_oe_selected", oe_v, 2'b11);
    chk("busy_selected", busy_v, 2'b11);
    chk("ready_after_start", ready_v, 2'b11);
    if (mid_load) do_load(mid_word, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      sclk_rise();
      if (i == nbits - 1) begin
        for (int k = 0; k < 2; k++) chk("underrun_during_word", und_c[k] - u0[k], exp_und_start);
      end
      sclk_fall();
    end
    for (int k = 0; k < 2; k++) begin
      chk("done_count", done_c[k] - d0[k], nbits / 8);
      chk("underrun_at_end_empty", und_c[k] - u0[k], exp_und_start + 1);
    end
    set_cs(1'b1);
    chk("miso_oe_deselected", oe_v, 2'b00);
    chk("busy_deselected", busy_v, 2'b00);
    chk("miso_deselected", miso_v, 2'b00);
    for (int k = 0; k < 2; k++) chk("no_abort", abort_c[k] - a0[k], 0);
    chk("sb_leftover", q0.size() + q1.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0[2], u0[2];
    vecs[0] = '{8'hA5, 1'b1, 0};
    vecs[1] = '{8'h01, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b0, 1};
    vecs[3] = '{8'h5A, 1'b1, 0};
    vecs[4] = '{8'hC3, 1'b1, 0};

    repeat (3) @(negedge clk);
    chk("reset_ready", ready_v, 2'b11);
    chk("reset_miso", miso_v, 2'b00);
    chk("reset_miso_oe", oe_v, 2'b00);
    chk("reset_busy", busy_v, 2'b00);
    chk("reset_pulses", {done_v, und_v, abort_v}, 6'b0);
    clrn = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      $display("txn %0d: word %02h preload=%0d", i, vecs[i].word, vecs[i].preload);
      if (vecs[i].preload) do_load(vecs[i].word, 1'b1);
      else push_word(vecs[i].word);
      transfer(8, vecs[i].exp_und_start, 1'b0, 8'h00);
    end

    $display("txn 5: back-to-back 3C then C3");
    do_load(8'h3C, 1'b1);
    transfer(16, 0, 1'b1, 8'hC3);

    $display("txn 6: abort after 3 bits of FF");
    do_load(8'hFF, 1'b1);
    a0 = abort_c;
    u0 = und_c;
    set_cs(1'b0);
    repeat (3) begin
      sclk_rise();
      sclk_fall();
    end
    set_cs(1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("abort_pulse", abort_c[k] - a0[k], 1);
      chk("abort_no_underrun", und_c[k] - u0[k], 0);
    end
    chk("abort_miso_oe", oe_v, 2'b00);
    chk("abort_busy", busy_v, 2'b00);
    chk("abort_miso", miso_v, 2'b00);
    chk("abort_ready", ready_v, 2'b11);
    chk("abort_bits_left", q0.size(), 5);
    q0.delete();
    q1.delete();

    $display("txn 7: word 81 after abort");
    do_load(8'h81, 1'b1);
    transfer(8, 0, 1'b0, 8'h00);

    $display("txn 8: load 55 then ignored load AA");
    do_load(8'h55, 1'b1);
    do_load(8'hAA, 1'b0);
    transfer(8, 0, 1'b0, 8'h00);

    $display("txn 9: reset mid-word of 66");
    do_load(8'h66, 1'b1);
    set_cs(1'b0);
    repeat (3) begin
      sclk_rise();
      sclk_fall();
    end
    @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("rst_mid_miso_oe", oe_v, 2'b00);
    chk("rst_mid_busy", busy_v, 2'b00);
    chk("rst_mid_ready", ready_v, 2'b11);
    chk("rst_mid_miso", miso_v, 2'b00);
    chk("rst_mid_pulses", {done_v, und_v, abort_v}, 6'b0);
    cs_n = 1'b1;
    sclk = 1'b0;
    q0.delete();
    q1.delete();
    repeat (4) @(negedge clk);
    clrn = 1'b1;
    repeat (HALF) @(negedge clk);

    $display("txn 10: word 99 after reset");
    do_load(8'h99, 1'b1);
    transfer(8, 0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
